mult_checker: RTL and testbench

- Clocked checker that sits directly downstream of the combinational reference multiplier.
- Accepts operand pairs with the reference product (ref_s = a*b, signed, 2*TAM bits) and buffers them in an alignment FIFO.
- Compares each buffered product against a pipelined multiplier under test (DUT) that returns results some cycles later.
- Reports pass/fail, error count and the first mismatching vector for the comparison bench.

---
 rtl/mult_checker_pkg.sv | 17 +
 rtl/mult_checker_if.sv | 37 +++
 rtl/mult_checker_fifo.sv | 46 ++++
 rtl/mult_checker.sv | 150 +++++++++++++++
 tb/tb_mult_checker.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_checker_pkg.sv
// Shared widths, default sizing and FSM encoding for the multiplier result checker.
package mult_checker_pkg;

  localparam int unsigned CHK_TAM   = 8;
  localparam int unsigned CHK_DEPTH = 16;
  localparam int unsigned CHK_NVEC  = 256;
  localparam int unsigned CHK_CNT_W = 16;
  localparam int unsigned CHK_TOUT  = 64;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } chk_state_e;

endpackage

// File: rtl/mult_checker_if.sv
// Stimulus, DUT-result and report signals of the checker, grouped as one bus.
interface mult_checker_if #(
  parameter int unsigned TAM   = mult_checker_pkg::CHK_TAM,
  parameter int unsigned CNT_W = mult_checker_pkg::CHK_CNT_W
);
  logic               start;
  logic               in_valid;
  logic [TAM-1:0]     a;
  logic [TAM-1:0]     b;
  logic [2*TAM-1:0]   ref_s;
  logic               dut_valid;
  logic [2*TAM-1:0]   dut_s;
  logic               in_ready;
  logic               busy;
  logic               done;
  logic               pass;
  logic [CNT_W-1:0]   err_count;
  logic [CNT_W-1:0]   vec_count;
  logic               timeout;
  logic               orphan;
  logic [TAM-1:0]     first_a;
  logic [TAM-1:0]     first_b;
  logic [2*TAM-1:0]   first_ref;
  logic [2*TAM-1:0]   first_dut;

  modport master (
    output start, in_valid, a, b, ref_s, dut_valid, dut_s,
    input  in_ready, busy, done, pass, err_count, vec_count, timeout, orphan,
    input  first_a, first_b, first_ref, first_dut
  );

  modport slave (
    input  start, in_valid, a, b, ref_s, dut_valid, dut_s,
    output in_ready, busy, done, pass, err_count, vec_count, timeout, orphan,
    output first_a, first_b, first_ref, first_dut
  );
endinterface

// File: rtl/mult_checker_fifo.sv
// Alignment FIFO: synchronous, show-ahead head, extra pointer MSB separates full from empty.
module mult_chk_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // A pop on an empty FIFO never sees the word being pushed that cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mult_checker.sv
// Compares buffered reference products against in-order results of a pipelined multiplier.
module mult_checker
  import mult_checker_pkg::*;
#(
  parameter int unsigned TAM   = CHK_TAM,
  parameter int unsigned DEPTH = CHK_DEPTH,
  parameter int unsigned NVEC  = CHK_NVEC,
  parameter int unsigned CNT_W = CHK_CNT_W,
  parameter int unsigned TOUT  = CHK_TOUT
) (
  input  logic           clk,
  input  logic           rst,
  mult_checker_if.slave  bus
);
  localparam int unsigned PW   = 2 * TAM;
  localparam int unsigned FW   = 2 * TAM + 2 * TAM;
  localparam int unsigned ACCW = $clog2(NVEC + 1);
  localparam int unsigned TW   = $clog2(TOUT + 1);

  chk_state_e       state_q;
  logic [ACCW-1:0]  acc_q;
  logic [TW-1:0]    tcnt_q;
  logic [CNT_W-1:0] err_count_q, vec_count_q;
  logic             timeout_q, orphan_q;
  logic [TAM-1:0]   first_a_q, first_b_q;
  logic [PW-1:0]    first_ref_q, first_dut_q;
  // Registered comparison stage between pop and error bookkeeping.
  logic             cmp_err_q, cmp_orph_q;
  logic [TAM-1:0]   cmp_a_q, cmp_b_q;
  logic [PW-1:0]    cmp_ref_q, cmp_dut_q;

  logic             start_ok, active, chk, pop, orph_ev, push, in_ready, full, empty;
  logic [FW-1:0]    head;
  logic [TAM-1:0]   head_a, head_b;
  logic [PW-1:0]    head_ref;

  assign start_ok = bus.start && (state_q == StIdle || state_q == StDone);
  assign active   = (state_q == StRun) || (state_q == StDrain);
  assign chk      = bus.dut_valid && active;
  assign pop      = chk && !empty;
  assign orph_ev  = chk && empty;
  assign in_ready = (state_q == StRun) && !full && (acc_q < ACCW'(NVEC));
  assign push     = bus.in_valid && in_ready;
  assign head_a   = head[FW-1 -: TAM];
  assign head_b   = head[PW+TAM-1 -: TAM];
  assign head_ref = head[PW-1:0];

  mult_chk_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .push  (push),
    .pop   (pop),
    .din   ({bus.a, bus.b, bus.ref_s}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      tcnt_q      <= '0;
      err_count_q <= '0;
      vec_count_q <= '0;
      timeout_q   <= 1'b0;
      orphan_q    <= 1'b0;
      first_a_q   <= '0;
      first_b_q   <= '0;
      first_ref_q <= '0;
      first_dut_q <= '0;
      cmp_err_q   <= 1'b0;
      cmp_orph_q  <= 1'b0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      cmp_ref_q   <= '0;
      cmp_dut_q   <= '0;
    end else if (start_ok) begin
      state_q     <= StRun;
      acc_q       <= '0;
      tcnt_q      <= '0;
      err_count_q <= '0;
      vec_count_q <= '0;
      timeout_q   <= 1'b0;
      orphan_q    <= 1'b0;
      first_a_q   <= '0;
      first_b_q   <= '0;
      first_ref_q <= '0;
      first_dut_q <= '0;
      cmp_err_q   <= 1'b0;
      cmp_orph_q  <= 1'b0;
    end else begin
      cmp_err_q  <= orph_ev || (pop && (head_ref != bus.dut_s));
      cmp_orph_q <= orph_ev;
      cmp_a_q    <= orph_ev ? '0 : head_a;
      cmp_b_q    <= orph_ev ? '0 : head_b;
      cmp_ref_q  <= orph_ev ? '0 : head_ref;
      cmp_dut_q  <= bus.dut_s;
      if (push) acc_q <= acc_q + 1'b1;
      if (pop && (vec_count_q != '1)) vec_count_q <= vec_count_q + 1'b1;
      if (cmp_err_q) begin
        if (err_count_q == '0) begin
          first_a_q   <= cmp_a_q;
          first_b_q   <= cmp_b_q;
          first_ref_q <= cmp_ref_q;
          first_dut_q <= cmp_dut_q;
        end
        if (err_count_q != '1) err_count_q <= err_count_q + 1'b1;
      end
      if (cmp_orph_q) orphan_q <= 1'b1;
      case (state_q)
        StRun: begin
          tcnt_q <= '0;
          if (acc_q == ACCW'(NVEC)) state_q <= StDrain;
        end
        StDrain: begin
          if (empty) begin
            state_q <= StDone;
          end else if (bus.dut_valid) begin
            tcnt_q <= '0;
          end else if (tcnt_q == TW'(TOUT - 1)) begin
            state_q   <= StDone;
            timeout_q <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = active;
  assign bus.done      = (state_q == StDone);
  assign bus.pass      = (state_q == StDone) && (err_count_q == '0) && !timeout_q && !orphan_q;
  assign bus.err_count = err_count_q;
  assign bus.vec_count = vec_count_q;
  assign bus.timeout   = timeout_q;
  assign bus.orphan    = orphan_q;
  assign bus.first_a   = first_a_q;
  assign bus.first_b   = first_b_q;
  assign bus.first_ref = first_ref_q;
  assign bus.first_dut = first_dut_q;

endmodule

// File: tb/tb_mult_checker.sv
// Directed bench: two checker instances (deep FIFO/NVEC=4 and DEPTH=4/NVEC=8) behind a latency-3 DUT model.
module tb_mult_checker;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sel, start, in_valid, inj_valid, dut_en;
  logic [7:0]  a, b;
  logic [15:0] ref_s, inj_s;
  int          corrupt_idx, max_results;
  int          n_chk = 0;
  int          n_fail = 0;

  logic [7:0]  va [4] = '{8'd3, 8'hF9, 8'h80, 8'h7F};
  logic [7:0]  vb [4] = '{8'd5, 8'd9, 8'h80, 8'hFF};
  logic [15:0] vr [4] = '{16'h000F, 16'hFFC1, 16'h4000, 16'hFF81};

  mult_checker_if #(.TAM(8), .CNT_W(16)) if0 ();
  mult_checker_if #(.TAM(8), .CNT_W(16)) if1 ();

  mult_checker #(.TAM(8), .DEPTH(16), .NVEC(4), .CNT_W(16), .TOUT(64)) u0 (
    .clk (clk), .rst (rst), .bus (if0.slave)
  );
  mult_checker #(.TAM(8), .DEPTH(4), .NVEC(8), .CNT_W(16), .TOUT(64)) u1 (
    .clk (clk), .rst (rst), .bus (if1.slave)
  );

  // Latency-3 multiplier model; result index corrupt_idx comes back as product-1.
  typedef struct {logic [15:0] val; int due;} res_t;
  res_t        q[$];
  int          cyc, acc_idx, sent;
  logic        mdl_valid;
  logic [15:0] mdl_s;
  logic        m_in_ready, m_busy, m_done, m_pass, m_timeout, m_orphan;
  logic [15:0] m_err, m_vec, m_fref, m_fdut;
  logic [7:0]  m_fa, m_fb;

  assign if0.start     = start & ~sel;
  assign if1.start     = start & sel;
  assign if0.in_valid  = in_valid & ~sel;
  assign if1.in_valid  = in_valid & sel;
  assign if0.a = a;  assign if1.a = a;
  assign if0.b = b;  assign if1.b = b;
  assign if0.ref_s = ref_s;
  assign if1.ref_s = ref_s;
  assign if0.dut_valid = (mdl_valid | inj_valid) & ~sel;
  assign if1.dut_valid = (mdl_valid | inj_valid) & sel;
  assign if0.dut_s     = inj_valid ? inj_s : mdl_s;
  assign if1.dut_s     = inj_valid ? inj_s : mdl_s;

  assign m_in_ready = sel ? if1.in_ready  : if0.in_ready;
  assign m_busy     = sel ? if1.busy      : if0.busy;
  assign m_done     = sel ? if1.done      : if0.done;
  assign m_pass     = sel ? if1.pass      : if0.pass;
  assign m_timeout  = sel ? if1.timeout   : if0.timeout;
  assign m_orphan   = sel ? if1.orphan    : if0.orphan;
  assign m_err      = sel ? if1.err_count : if0.err_count;
  assign m_vec      = sel ? if1.vec_count : if0.vec_count;
  assign m_fa       = sel ? if1.first_a   : if0.first_a;
  assign m_fb       = sel ? if1.first_b   : if0.first_b;
  assign m_fref     = sel ? if1.first_ref : if0.first_ref;
  assign m_fdut     = sel ? if1.first_dut : if0.first_dut;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      cyc <= 0; acc_idx <= 0; sent <= 0; mdl_valid <= 1'b0; mdl_s <= '0;
    end else begin
      cyc <= cyc + 1;
      mdl_valid <= 1'b0;
      if (start) begin
        q.delete();
        acc_idx <= 0;
        sent <= 0;
      end else if (in_valid && m_in_ready) begin
        q.push_back('{val: (acc_idx == corrupt_idx) ? ref_s - 16'd1 : ref_s, due: cyc + 3});
        acc_idx <= acc_idx + 1;
      end
      if (dut_en && q.size() > 0 && sent < max_results) begin
        if (q[0].due <= cyc) begin
          mdl_valid <= 1'b1;
          mdl_s <= q[0].val;
          q.pop_front();
          sent <= sent + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_vec(input int i);
    int n = 0;
    a = va[i]; b = vb[i]; ref_s = vr[i]; in_valid = 1'b1;
    while (!m_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!m_in_ready) chk("push_ready", {31'd0, m_in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!m_done && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'd0, m_done}, 32'd1);
  endtask

  task automatic inject(input logic [15:0] v);
    inj_s = v; inj_valid = 1'b1;
    @(negedge clk);
    inj_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; start = 1'b0; in_valid = 1'b0; a = '0; b = '0; ref_s = '0;
    inj_valid = 1'b0; inj_s = '0; dut_en = 1'b1; corrupt_idx = -1; max_results = 1000;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, m_busy}, 32'd0);
    chk("rst_done", {31'd0, m_done}, 32'd0);
    chk("rst_pass", {31'd0, m_pass}, 32'd0);
    chk("rst_ready", {31'd0, m_in_ready}, 32'd0);
    chk("rst_err", {16'd0, m_err}, 32'd0);
    chk("rst_vec", {16'd0, m_vec}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Clean run of four vectors.
    pulse_start();
    chk("t1_busy", {31'd0, m_busy}, 32'd1);
    chk("t1_ready", {31'd0, m_in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) push_vec(i);
    wait_done(100);
    chk("t1_pass", {31'd0, m_pass}, 32'd1);
    chk("t1_err", {16'd0, m_err}, 32'd0);
    chk("t1_vec", {16'd0, m_vec}, 32'd4);
    chk("t1_busy_end", {31'd0, m_busy}, 32'd0);

    // Third result returned as 16383 instead of 16384.
    corrupt_idx = 2;
    pulse_start();
    chk("t2_cleared", {31'd0, m_done}, 32'd0);
    for (int i = 0; i < 4; i++) push_vec(i);
    wait_done(100);
    chk("t2_err", {16'd0, m_err}, 32'd1);
    chk("t2_pass", {31'd0, m_pass}, 32'd0);
    chk("t2_vec", {16'd0, m_vec}, 32'd4);
    chk("t2_first_a", {24'd0, m_fa}, 32'h80);
    chk("t2_first_b", {24'd0, m_fb}, 32'h80);
    chk("t2_first_ref", {16'd0, m_fref}, 32'h4000);
    chk("t2_first_dut", {16'd0, m_fdut}, 32'h3FFF);
    corrupt_idx = -1;

    // Orphan result with nothing queued; start mid-run is ignored.
    pulse_start();
    inject(16'h1234);
    @(negedge clk);
    chk("t3_orphan", {31'd0, m_orphan}, 32'd1);
    chk("t3_err", {16'd0, m_err}, 32'd1);
    chk("t3_first_dut", {16'd0, m_fdut}, 32'h1234);
    chk("t3_first_ref", {16'd0, m_fref}, 32'h0);
    chk("t3_vec", {16'd0, m_vec}, 32'd0);
    pulse_start();
    chk("t3_start_ignored", {16'd0, m_err}, 32'd1);
    for (int i = 0; i < 4; i++) push_vec(i);
    wait_done(100);
    chk("t3_pass", {31'd0, m_pass}, 32'd0);
    chk("t3_vec_end", {16'd0, m_vec}, 32'd4);
    chk("t3_err_end", {16'd0, m_err}, 32'd1);

    // Only one result ever returns: drain times out.
    max_results = 1;
    pulse_start();
    for (int i = 0; i < 4; i++) push_vec(i);
    repeat (50) @(negedge clk);
    chk("t4_still_busy", {31'd0, m_busy}, 32'd1);
    wait_done(100);
    chk("t4_timeout", {31'd0, m_timeout}, 32'd1);
    chk("t4_pass", {31'd0, m_pass}, 32'd0);
    chk("t4_vec", {16'd0, m_vec}, 32'd1);
    chk("t4_err", {16'd0, m_err}, 32'd0);
    max_results = 1000;

    // Asynchronous reset mid-run with two entries queued and an error recorded.
    dut_en = 1'b0;
    pulse_start();
    inject(16'h00AA);
    push_vec(0);
    push_vec(1);
    chk("t5_pre_err", {16'd0, m_err}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_busy", {31'd0, m_busy}, 32'd0);
    chk("t5_async_err", {16'd0, m_err}, 32'd0);
    chk("t5_async_orphan", {31'd0, m_orphan}, 32'd0);
    chk("t5_async_fdut", {16'd0, m_fdut}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dut_en = 1'b1;
    @(negedge clk);
    pulse_start();
    for (int i = 0; i < 4; i++) push_vec(i);
    wait_done(100);
    chk("t5_pass", {31'd0, m_pass}, 32'd1);
    chk("t5_vec", {16'd0, m_vec}, 32'd4);

    // DEPTH=4 instance: DUT stalls until the FIFO fills, then push and pop overlap.
    sel = 1'b1;
    dut_en = 1'b0;
    @(negedge clk);
    pulse_start();
    for (int i = 0; i < 4; i++) push_vec(i);
    chk("t6_full_ready", {31'd0, m_in_ready}, 32'd0);
    chk("t6_busy", {31'd0, m_busy}, 32'd1);
    dut_en = 1'b1;
    for (int i = 0; i < 4; i++) push_vec(i);
    wait_done(100);
    chk("t6_pass", {31'd0, m_pass}, 32'd1);
    chk("t6_vec", {16'd0, m_vec}, 32'd8);
    chk("t6_err", {16'd0, m_err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
